// File: rtl/set_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// set_pkg : command layout, mode codes and FSM encoding for the SET issuer
// Rev 1.0
// ----------------------------------------------------------------------------
package set_pkg;

  localparam logic [1:0] MODE_A   = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int MODE_W    = 2;
  localparam int CAND_W    = 8;
  localparam int TOCNT_W   = 8;
  localparam int CMD_W     = MODE_W + RADIUS_W + CENTRAL_W;

  typedef struct packed {
    logic [MODE_W-1:0]    mode;
    logic [RADIUS_W-1:0]  radius;
    logic [CENTRAL_W-1:0] central;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic logic is_bad_mode(input logic [MODE_W-1:0] m);
    return m == MODE_BAD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/set_cmd_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// set_cmd_fifo : synchronous FIFO with wrap-bit pointers and full/empty flags
// Rev 1.0
// ----------------------------------------------------------------------------
module set_cmd_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             w_full;
  logic             w_empty;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A write into a full queue is allowed when the same cycle frees a slot.
  assign w_do_rd = rd_en_i && !w_empty;
  assign w_do_wr = wr_en_i && (!w_full || w_do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o    = w_full;
  assign empty_o   = w_empty;

endmodule
`default_nettype wire

// File: rtl/set_cmd_issuer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// set_cmd_issuer : queues SET jobs, sequences one job at a time, returns tagged results
// Rev 1.0
// ----------------------------------------------------------------------------
module set_cmd_issuer
  import set_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 127,
  parameter int TAG_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CENTRAL_W-1:0] cmd_central,
  input  logic [RADIUS_W-1:0]  cmd_radius,
  input  logic [MODE_W-1:0]    cmd_mode,
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [MODE_W-1:0]    set_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [CAND_W-1:0]    set_candidate,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CAND_W-1:0]    res_candidate,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 res_err,
  output logic [TOCNT_W-1:0]   timeout_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int FW    = CMD_W + TAG_W;

  logic [FW-1:0]      w_push_data;
  logic [FW-1:0]      w_head;
  cmd_t               w_head_cmd;
  logic [TAG_W-1:0]   w_head_tag;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   tag_d;
  state_e             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic               set_en_q;
  cmd_t               set_cmd_q;
  logic [CAND_W-1:0]  job_cand_q;
  logic               job_err_q;
  logic [TAG_W-1:0]   job_tag_q;
  logic               res_valid_q;
  logic [CAND_W-1:0]  res_cand_q;
  logic [TAG_W-1:0]   res_tag_q;
  logic               res_err_q;
  logic [TOCNT_W-1:0] tocnt_q;
  logic [TOCNT_W-1:0] tocnt_d;

  assign cmd_ready   = !w_full;
  assign w_push      = cmd_valid && !w_full;
  assign w_push_data = {tag_q, cmd_mode, cmd_radius, cmd_central};
  assign w_head_tag  = w_head[FW-1:CMD_W];
  assign w_head_cmd  = cmd_t'(w_head[CMD_W-1:0]);

  // Single-entry result buffer: nothing is dequeued until the last result left.
  assign w_pop = (state_q == ST_IDLE) && !w_empty && !res_valid_q && !set_busy;

  set_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (w_push),
    .wr_data_i (w_push_data),
    .rd_en_i   (w_pop),
    .rd_data_o (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  assign tag_d   = w_push ? tag_q + 1'b1 : tag_q;
  assign tocnt_d = (tocnt_q == {TOCNT_W{1'b1}}) ? tocnt_q : tocnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      set_en_q    <= 1'b0;
      set_cmd_q   <= '0;
      job_cand_q  <= '0;
      job_err_q   <= 1'b0;
      job_tag_q   <= '0;
      res_valid_q <= 1'b0;
      res_cand_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
      tocnt_q     <= '0;
    end else begin
      if (res_valid_q && res_ready) res_valid_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (w_pop) begin
            job_tag_q <= w_head_tag;
            if (is_bad_mode(w_head_cmd.mode)) begin
              job_err_q  <= 1'b1;
              job_cand_q <= '0;
              state_q    <= ST_RESP;
            end else begin
              set_cmd_q <= w_head_cmd;
              set_en_q  <= 1'b1;
              state_q   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          set_en_q <= 1'b0;
          timer_q  <= '0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (set_valid) begin
            job_cand_q <= set_candidate;
            job_err_q  <= 1'b0;
            state_q    <= ST_DRAIN;
          end else if (timer_q == TMR_W'(TIMEOUT)) begin
            job_cand_q <= '0;
            job_err_q  <= 1'b1;
            tocnt_q    <= tocnt_d;
            state_q    <= ST_DRAIN;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // SET must be idle again before the next job may start.
          if (!set_busy) state_q <= ST_RESP;
        end
        ST_RESP: begin
          res_valid_q <= 1'b1;
          res_cand_q  <= job_cand_q;
          res_tag_q   <= job_tag_q;
          res_err_q   <= job_err_q;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign set_en        = set_en_q;
  assign set_central   = set_cmd_q.central;
  assign set_radius    = set_cmd_q.radius;
  assign set_mode      = set_cmd_q.mode;
  assign res_valid     = res_valid_q;
  assign res_candidate = res_cand_q;
  assign res_tag       = res_tag_q;
  assign res_err       = res_err_q;
  assign timeout_cnt   = tocnt_q;

endmodule
`default_nettype wire

// File: tb/tb_set_cmd_issuer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_set_cmd_issuer : directed vectors for set_cmd_issuer with a behavioural SET
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_set_cmd_issuer;

  localparam int SET_CYC = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_central = '0;
  logic [11:0] cmd_radius = '0;
  logic [1:0]  cmd_mode = '0;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_candidate;
  logic [3:0]  res_tag;
  logic        res_err;
  logic [7:0]  timeout_cnt;

  always #5 clk = ~clk;

  set_cmd_issuer #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (127),
    .TAG_W      (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_central   (cmd_central),
    .cmd_radius    (cmd_radius),
    .cmd_mode      (cmd_mode),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_mode      (set_mode),
    .set_busy      (set_busy),
    .set_valid     (set_valid),
    .set_candidate (set_candidate),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_candidate (res_candidate),
    .res_tag       (res_tag),
    .res_err       (res_err),
    .timeout_cnt   (timeout_cnt)
  );

  // Behavioural SET: counts 16x16 grid points inside circle A and/or B.
  function automatic logic [7:0] set_count(input logic [23:0] c, input logic [11:0] r,
                                           input logic [1:0] m);
    int x1, y1, x2, y2, r1, r2, n;
    bit a, b;
    x1 = int'(c[23:20]); y1 = int'(c[19:16]);
    x2 = int'(c[15:12]); y2 = int'(c[11:8]);
    r1 = int'(r[11:8]);  r2 = int'(r[7:4]);
    n = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a = ((x - x1) * (x - x1) + (y - y1) * (y - y1)) <= r1 * r1;
        b = ((x - x2) * (x - x2) + (y - y2) * (y - y2)) <= r2 * r2;
        case (m)
          2'b00:   n = n + (a ? 1 : 0);
          2'b01:   n = n + ((a && b) ? 1 : 0);
          2'b10:   n = n + ((a ^ b) ? 1 : 0);
          default: n = n;
        endcase
      end
    end
    return n[7:0];
  endfunction

  logic       m_busy;
  logic       m_valid;
  logic [7:0] m_cand;
  int         m_cnt;
  bit         drop_valid = 1'b0;
  bit         stuck_busy = 1'b0;

  assign set_busy      = m_busy | stuck_busy;
  assign set_valid     = m_valid;
  assign set_candidate = m_cand;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_cand  <= '0;
      m_cnt   <= 0;
    end else begin
      m_valid <= 1'b0;
      if (set_en && !m_busy) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end else if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == SET_CYC - 1) begin
          m_valid <= !drop_valid;
          m_cand  <= set_count(set_central, set_radius, set_mode);
        end
        if (m_cnt == SET_CYC) m_busy <= 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] cand;
    logic       err;
  } res_t;

  res_t       res_fifo[$];
  int         en_cnt = 0;
  int         en_busy_err = 0;
  int         stab_err = 0;
  logic       hold_q = 1'b0;
  logic [7:0] hold_cand;
  logic [3:0] hold_tag;
  logic       hold_err;

  // Mid-cycle monitor: en/busy overlap, result stability and delivered results.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
    end else begin
      if (set_en) en_cnt <= en_cnt + 1;
      if (set_en && set_busy) en_busy_err <= en_busy_err + 1;
      if (hold_q && res_valid &&
          ({res_tag, res_candidate, res_err} != {hold_tag, hold_cand, hold_err}))
        stab_err <= stab_err + 1;
      hold_q    <= res_valid && !res_ready;
      hold_cand <= res_candidate;
      hold_tag  <= res_tag;
      hold_err  <= res_err;
      if (res_valid && res_ready) res_fifo.push_back({res_tag, res_candidate, res_err});
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    cmd_valid   = 1'b1;
    cmd_central = c;
    cmd_radius  = r;
    cmd_mode    = m;
    for (int i = 0; i < 2000; i++) begin
      if (cmd_ready) begin
        tick();
        cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    cmd_valid = 1'b0;
    check_eq("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic expect_res(input string tag, input int etag, input int ecand,
                            input int eerr, output int waited);
    res_t r;
    waited = 0;
    while (res_fifo.size() == 0 && waited < 2000) begin
      tick();
      waited++;
    end
    if (res_fifo.size() == 0) begin
      check_eq({tag, "_timeout"}, 32'(0), 32'(1));
      return;
    end
    r = res_fifo.pop_front();
    check_eq({tag, "_tag"},  32'(r.tag),  etag);
    check_eq({tag, "_cand"}, 32'(r.cand), ecand);
    check_eq({tag, "_err"},  32'(r.err),  eerr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int e0;
    logic [23:0] t2_c [5];
    logic [11:0] t2_r [5];
    logic [1:0]  t2_m [5];
    int          t2_exp [5];
    t2_c = '{24'h440000, 24'h444400, 24'h444400, 24'h448800, 24'h445400};
    t2_r = '{12'h200,    12'h220,    12'h220,    12'h110,    12'h110};
    t2_m = '{2'b00,      2'b01,      2'b10,      2'b10,      2'b01};
    t2_exp = '{13, 13, 0, 10, 2};

    repeat (3) tick();
    check_eq("rst_res_valid", 32'(res_valid), 32'(0));
    check_eq("rst_res_cand",  32'(res_candidate), 32'(0));
    check_eq("rst_res_tag",   32'(res_tag), 32'(0));
    check_eq("rst_res_err",   32'(res_err), 32'(0));
    check_eq("rst_tocnt",     32'(timeout_cnt), 32'(0));
    check_eq("rst_set_en",    32'(set_en), 32'(0));
    check_eq("rst_central",   32'(set_central), 32'(0));
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    rst_n = 1'b1;
    tick();

    // Single basic job
    res_ready = 1'b1;
    e0 = en_cnt;
    send(24'h440000, 12'h200, 2'b00);
    expect_res("t1", 0, 13, 0, w);
    check_eq("t1_en_pulses", en_cnt - e0, 1);

    // Fill the queue while SET is held busy, then drain in order
    do_reset();
    stuck_busy = 1'b1;
    e0 = en_cnt;
    for (int i = 0; i < 4; i++) send(t2_c[i], t2_r[i], t2_m[i]);
    check_eq("t2_full_ready", 32'(cmd_ready), 32'(0));
    fork
      send(t2_c[4], t2_r[4], t2_m[4]);
      begin
        repeat (10) tick();
        check_eq("t2_no_en_busy", en_cnt - e0, 0);
        check_eq("t2_held_ready", 32'(cmd_ready), 32'(0));
        stuck_busy = 1'b0;
      end
    join
    for (int i = 0; i < 5; i++) expect_res($sformatf("t2_%0d", i), i, t2_exp[i], 0, w);
    check_eq("t2_en_pulses", en_cnt - e0, 5);

    // Illegal mode: fast error, no en
    e0 = en_cnt;
    send(24'h440000, 12'h200, 2'b11);
    expect_res("t3", 5, 0, 1, w);
    check_eq("t3_latency", 32'(w <= 3), 32'(1));
    check_eq("t3_no_en", en_cnt - e0, 0);

    // Timeout when SET never strobes valid
    drop_valid = 1'b1;
    send(24'h440000, 12'h200, 2'b00);
    expect_res("t4", 6, 0, 1, w);
    check_eq("t4_to_latency", 32'(w >= 128 && w <= 140), 32'(1));
    check_eq("t4_tocnt", 32'(timeout_cnt), 32'(1));
    drop_valid = 1'b0;
    send(24'h448800, 12'h110, 2'b10);
    expect_res("t4_next", 7, 10, 0, w);

    // Back-pressure on the result port
    res_ready = 1'b0;
    e0 = en_cnt;
    send(24'h440000, 12'h200, 2'b00);
    send(24'h445400, 12'h110, 2'b01);
    repeat (200) tick();
    check_eq("t5_res_valid", 32'(res_valid), 32'(1));
    check_eq("t5_res_tag",   32'(res_tag), 32'(8));
    check_eq("t5_res_cand",  32'(res_candidate), 32'(13));
    check_eq("t5_res_err",   32'(res_err), 32'(0));
    check_eq("t5_en_withheld", en_cnt - e0, 1);
    check_eq("t5_stable", stab_err, 0);
    res_ready = 1'b1;
    expect_res("t5a", 8, 13, 0, w);
    expect_res("t5b", 9, 2, 0, w);

    // Reset during WAIT
    send(24'h440000, 12'h200, 2'b00);
    for (int i = 0; i < 20 && !set_busy; i++) tick();
    check_eq("t6_busy", 32'(set_busy), 32'(1));
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check_eq("t6_set_en",    32'(set_en), 32'(0));
    check_eq("t6_res_valid", 32'(res_valid), 32'(0));
    check_eq("t6_res_tag",   32'(res_tag), 32'(0));
    check_eq("t6_res_cand",  32'(res_candidate), 32'(0));
    check_eq("t6_tocnt",     32'(timeout_cnt), 32'(0));
    check_eq("t6_central",   32'(set_central), 32'(0));
    check_eq("t6_mode",      32'(set_mode), 32'(0));
    check_eq("t6_cmd_ready", 32'(cmd_ready), 32'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_eq("t6_no_stale", res_fifo.size(), 0);
    send(24'h440000, 12'h200, 2'b00);
    expect_res("t6", 0, 13, 0, w);

    check_eq("en_while_busy", en_busy_err, 0);
    check_eq("res_stability", stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
